// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for an 8-digit seven-segment display.
// New values are double-buffered and only committed on a frame wrap (sel 7->0),
// so a frame is always drawn from one consistent snapshot. seg/dp/blank are
// registered together with sel so the cathodes always match the selected digit.
module display_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        lz_en,
    output logic [2:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        blank,
    output logic        frame_start
);

    localparam int            CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF  = 7'h7F;

    // Hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Prescaler and scan position
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          tick;
    logic [2:0]    sel_reg;
    logic [2:0]    sel_next;
    logic          frame_wrap;

    // Pending (loaded) and active (displayed) buffers
    logic [31:0] pending_data_reg;
    logic [7:0]  pending_dp_reg;
    logic [7:0]  pending_en_reg;
    logic        pending_valid_reg;
    logic [31:0] active_data_reg;
    logic [7:0]  active_dp_reg;
    logic [7:0]  active_en_reg;
    logic        commit;
    logic [31:0] active_data_next;
    logic [7:0]  active_dp_next;
    logic [7:0]  active_en_next;

    // Registered cathode outputs
    logic [6:0] seg_reg;
    logic [6:0] seg_next;
    logic       dp_reg;
    logic       dp_next;
    logic       blank_reg;
    logic       blank_next;
    logic       frame_start_reg;

    // Per-digit decode of the buffer contents that will be active after this edge
    logic [6:0] digit_seg [8];
    logic [7:0] digit_blank;
    logic [7:0] digit_lz;

    assign tick       = (count_reg == LAST_CNT);
    assign count_next = tick ? '0 : count_reg + 1'b1;
    assign sel_next   = tick ? sel_reg + 3'd1 : sel_reg;
    assign frame_wrap = tick && (sel_reg == 3'd7);
    assign commit     = frame_wrap && pending_valid_reg;

    // The outputs for the new digit are computed from the post-commit buffer,
    // so the first digit of a frame already shows the freshly committed value.
    assign active_data_next = commit ? pending_data_reg : active_data_reg;
    assign active_dp_next   = commit ? pending_dp_reg   : active_dp_reg;
    assign active_en_next   = commit ? pending_en_reg   : active_en_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_seg[gi] = hex_to_seg(active_data_next[4*gi +: 4]);

            // Digit 0 is never zero-suppressed so a value of zero still shows "0".
            if (gi == 0) begin : g_no_lz
                assign digit_lz[gi] = 1'b0;
            end else begin : g_lz
                assign digit_lz[gi] = lz_en && (active_data_next[31:4*gi] == '0);
            end

            assign digit_blank[gi] = ~active_en_next[gi] | digit_lz[gi];
        end
    endgenerate

    // Select the cathode pattern for the digit that sel is about to show.
    always_comb begin
        seg_next   = SEG_OFF;
        dp_next    = 1'b1;
        blank_next = 1'b1;
        if (!digit_blank[sel_next]) begin
            seg_next   = digit_seg[sel_next];
            dp_next    = ~active_dp_next[sel_next];
            blank_next = 1'b0;
        end
    end

    // Free-running prescaler; load never disturbs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Scan position, frame pulse and cathodes all step together on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg         <= 3'd0;
            seg_reg         <= SEG_OFF;
            dp_reg          <= 1'b1;
            blank_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= frame_wrap;
            if (tick) begin
                sel_reg   <= sel_next;
                seg_reg   <= seg_next;
                dp_reg    <= dp_next;
                blank_reg <= blank_next;
            end
        end
    end

    // Double buffer: load fills pending; a frame wrap moves pending to active.
    // A load on the commit edge lands in pending after the old value moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_data_reg  <= '0;
            pending_dp_reg    <= '0;
            pending_en_reg    <= '0;
            pending_valid_reg <= 1'b0;
            active_data_reg   <= '0;
            active_dp_reg     <= '0;
            active_en_reg     <= '0;
        end else begin
            active_data_reg <= active_data_next;
            active_dp_reg   <= active_dp_next;
            active_en_reg   <= active_en_next;
            if (load) begin
                pending_data_reg  <= data_in;
                pending_dp_reg    <= dp_in;
                pending_en_reg    <= digit_en;
                pending_valid_reg <= 1'b1;
            end else if (commit) begin
                pending_valid_reg <= 1'b0;
            end
        end
    end

    assign sel         = sel_reg;
    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign blank       = blank_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with a short refresh divider.
// Stimulus pushes the expected cathode state for every digit slot; a monitor
// pops one entry whenever sel steps and compares the whole output bundle.
module tb_display_scanner;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = '0;
    logic        lz_en = 1'b0;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        blank;
    logic        frame_start;

    typedef struct packed {
        logic [2:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       blank;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_en       (lz_en),
        .sel         (sel),
        .seg         (seg),
        .dp          (dp),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Hand-computed frame images, digit 7 on the left, digit 0 on the right.
    localparam logic [55:0] SEGS_BLANK = {8{7'h7F}};
    localparam logic [55:0] SEGS_HEX   = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [55:0] SEGS_TWO   = {8{7'h24}};
    localparam logic [55:0] SEGS_FOUR  = {8{7'h19}};
    localparam logic [55:0] SEGS_THREE = {8{7'h30}};
    localparam logic [55:0] SEGS_LZ50  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [55:0] SEGS_LZ0   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [55:0] SEGS_EN_F0 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sel"},   32'(sel),         32'd0);
        check({tag, "_seg"},   32'(seg),         32'h7F);
        check({tag, "_dp"},    32'(dp),          32'd1);
        check({tag, "_blank"}, 32'(blank),       32'd1);
        check({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    task automatic push_frame(input logic [55:0] segs, input logic [7:0] dpn,
                              input logic [7:0] blk, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_t e;
            e.sel   = 3'(i);
            e.seg   = segs[7*i +: 7];
            e.dp    = dpn[i];
            e.blank = blk[i];
            e.fs    = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Wait for sel to step onto v; returns 1 time unit after that negedge.
    task automatic wait_sel(input logic [2:0] v);
        logic [2:0] last;
        bit         got;
        last = sel;
        got  = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (sel == v && last != v) got = 1'b1;
            last = sel;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL wait_sel: sel never stepped to %0d, now %0d", v, sel);
        end
        #1;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] en);
        data_in  = d;
        dp_in    = p;
        digit_en = en;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        digit_en = '0;
    endtask

    // Monitor: one scoreboard pop per sel step; frame_start must be low otherwise.
    task automatic monitor_loop();
        logic [2:0] prev_sel;
        exp_t       e;
        prev_sel = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sel = 3'd0;
            end else if (sel != prev_sel) begin
                prev_sel = sel;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL step: sel=%0d seg=%h with no expected entry", sel, seg);
                end else begin
                    e = exp_q.pop_front();
                    if ({sel, seg, dp, blank, frame_start} !== e) begin
                        mismatched++;
                        $display("FAIL step: got sel=%0d seg=%h dp=%b blank=%b fs=%b, expected sel=%0d seg=%h dp=%b blank=%b fs=%b",
                                 sel, seg, dp, blank, frame_start, e.sel, e.seg, e.dp, e.blank, e.fs);
                    end else begin
                        $display("step sel=%0d seg=%h dp=%b blank=%b fs=%b ok", sel, seg, dp, blank, frame_start);
                    end
                end
            end else begin
                compared++;
                if (frame_start !== 1'b0) begin
                    mismatched++;
                    $display("FAIL frame_start_width: got %b at sel=%0d, expected 0", frame_start, sel);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check_reset("reset");
        #1 rst_n = 1'b1;

        // Empty buffers: everything blank until the first load commits.
        push_frame(SEGS_BLANK, 8'hFF, 8'hFF, 1, 7);
        push_frame(SEGS_BLANK, 8'hFF, 8'hFF, 0, 7);

        // Frame 1: load mid-frame, shown only from the next wrap.
        wait_sel(3'd0);
        wait_sel(3'd3);
        do_load(32'h89ABCDEF, 8'h01, 8'hFF);
        $display("load 89ABCDEF dp=01 en=FF at sel=3");
        push_frame(SEGS_HEX, 8'hFE, 8'h00, 0, 7);

        // Frame 2: two loads, last one wins.
        wait_sel(3'd0);
        wait_sel(3'd2);
        do_load(32'h11111111, 8'h00, 8'hFF);
        $display("load 11111111");
        wait_sel(3'd4);
        do_load(32'h22222222, 8'h00, 8'hFF);
        $display("load 22222222");
        push_frame(SEGS_TWO, 8'hFF, 8'h00, 0, 7);

        // Frame 3: pending=4s, then load 3s on the exact commit edge.
        wait_sel(3'd0);
        wait_sel(3'd2);
        do_load(32'h44444444, 8'h00, 8'hFF);
        $display("load 44444444");
        push_frame(SEGS_FOUR, 8'hFF, 8'h00, 0, 7);
        push_frame(SEGS_THREE, 8'hFF, 8'h00, 0, 7);
        wait_sel(3'd7);
        repeat (DIV - 1) @(posedge clk);
        #1;
        do_load(32'h33333333, 8'h00, 8'hFF);
        $display("load 33333333 on commit edge");

        // Frame 5 (frame 4 shows 4s): leading-zero suppression.
        wait_sel(3'd0);
        wait_sel(3'd2);
        lz_en = 1'b1;
        do_load(32'h00000050, 8'h00, 8'hFF);
        $display("load 00000050 lz_en=1");
        push_frame(SEGS_LZ50, 8'hFF, 8'hFC, 0, 7);

        wait_sel(3'd0);
        wait_sel(3'd2);
        do_load(32'h00000000, 8'h00, 8'hFF);
        $display("load 00000000 lz_en=1");
        push_frame(SEGS_LZ0, 8'hFF, 8'hFE, 0, 7);

        // Digit enables: low four digits disabled.
        wait_sel(3'd0);
        wait_sel(3'd2);
        do_load(32'h12345678, 8'h00, 8'hF0);
        $display("load 12345678 en=F0");
        push_frame(SEGS_EN_F0, 8'hFF, 8'h0F, 0, 5);

        // Leave something pending, then reset mid-frame.
        wait_sel(3'd0);
        wait_sel(3'd4);
        do_load(32'hFFFFFFFF, 8'hFF, 8'hFF);
        $display("load FFFFFFFF (to be discarded by reset)");
        wait_sel(3'd5);
        check("queue_before_reset", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Pending must have been discarded: the next frame stays blank.
        push_frame(SEGS_BLANK, 8'hFF, 8'hFF, 1, 7);
        push_frame(SEGS_BLANK, 8'hFF, 8'hFF, 0, 0);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
